// File: rtl/irda_pkg.sv
// Frame constants and tx state encoding shared by the IrDA SIR transmit and receive paths.
package irda_pkg;

    localparam int NO_BIT       = 10;
    localparam int CLKS_PER_BIT = 16;
    localparam int PULSE_CLKS   = 3;
    localparam int SAMPLE_W     = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = 4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/irda_tx_if.sv
// Byte-load handshake and IR line outputs of the IrDA SIR transmitter.
interface irda_tx_if;

    logic       load;
    logic [7:0] tx_data;
    logic       ir_tx;
    logic       busy;
    logic       tx_done;

    modport master (output load, tx_data, input ir_tx, busy, tx_done);
    modport slave  (input load, tx_data, output ir_tx, busy, tx_done);

endinterface

// File: rtl/irda_tx_baud.sv
// Per-bit sample counter: counts 0..CLKS_PER_BIT-1 while enabled, bit_tick marks the wrap cycle.
module irda_tx_baud
    import irda_pkg::*;
(
    input  logic                clk,
    input  logic                clear_i,
    input  logic                en_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                bit_tick_o
);

    logic [SAMPLE_W-1:0] sample_q;
    logic [SAMPLE_W-1:0] sample_d;
    logic                at_max;

    assign at_max = (sample_q == SAMPLE_W'(CLKS_PER_BIT - 1));

    always_comb begin
        sample_d = sample_q;
        if (en_i) begin
            sample_d = at_max ? '0 : sample_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample_o   = sample_q;
    assign bit_tick_o = en_i && at_max;

endmodule

// File: rtl/irda_tx.sv
// IrDA SIR transmitter: frames a byte as start/8 data/stop and emits RZ pulses for 0 bits.
//
//   state | meaning
//   IDLE  | waiting for load, line quiet
//   SEND  | shifting out the 10-bit frame, one bit per CLKS_PER_BIT clocks
//   DONE  | single tx_done cycle; a load here chains the next frame
module irda_tx
    import irda_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    irda_tx_if.slave   bus
);

    tx_state_e           state_q;
    logic [NO_BIT-1:0]   shreg_q;
    logic [BIT_W-1:0]    bit_q;
    logic                ir_tx_q;
    logic                busy_q;
    logic                tx_done_q;

    logic                accept;
    logic                bit_tick;
    logic [SAMPLE_W-1:0] sample;

    assign accept = bus.load && (state_q == IDLE || state_q == DONE);

    irda_tx_baud u_baud (
        .clk        (clk),
        .clear_i    (clear || accept),
        .en_i       (state_q == SEND),
        .sample_o   (sample),
        .bit_tick_o (bit_tick)
    );

    // Outputs are loaded with the value for the cycle being entered, so they stay registered.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_q     <= '0;
            ir_tx_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    tx_done_q <= 1'b0;
                    if (bus.load) begin
                        state_q <= SEND;
                        shreg_q <= {STOP_BIT, bus.tx_data, START_BIT};
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        ir_tx_q <= ~START_BIT;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ir_tx_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (bit_tick) begin
                        if (bit_q == BIT_W'(NO_BIT - 1)) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            tx_done_q <= 1'b1;
                            ir_tx_q   <= 1'b0;
                        end else begin
                            shreg_q <= {STOP_BIT, shreg_q[NO_BIT-1:1]};
                            bit_q   <= bit_q + 1'b1;
                            ir_tx_q <= ~shreg_q[1];
                        end
                    end else begin
                        ir_tx_q <= ~shreg_q[0] && (sample < SAMPLE_W'(PULSE_CLKS - 1));
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    tx_done_q <= 1'b0;
                    ir_tx_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ir_tx   = ir_tx_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = tx_done_q;

endmodule
